execute_stage: RTL and testbench

- RV32IM EX stage. Consumes the ID/EX register, resolves operand forwarding, performs ALU and branch evaluation, and runs an iterative 32-bit divider.
- Registers its result into the EX/MEM pipeline register for the downstream memory stage.
- Raises ex_busy to freeze upstream stages while a divide is in flight.

---
 rtl/execute_pkg.sv | 65 ++++++
 rtl/execute_stage_div_unit.sv | 100 ++++++++++
 rtl/execute_stage.sv | 117 +++++++++++
 tb/tb_execute_stage.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared types for the RV32IM execute stage: pipeline register layouts,
// ALU/branch encodings, forwarding selects and divider FSM states.
package execute_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_PASSB, ALU_AUIPC, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  // Branch compare codes follow the RISC-V funct3 field.
  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  // A jump with alu_src=1 is JALR (register-relative target); otherwise JAL.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    alu_op_e     alu_op;
    logic [2:0]  br_op;
    logic        alu_src;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemToReg;
    logic        Branch;
    logic        Jump;
    logic        valid;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        RegWrite;
    logic        MemWrite;
    logic        MemToReg;
    logic        valid;
  } ex_mem_t;

  function automatic logic [31:0] fwd_mux(input logic [1:0] sel, input logic [31:0] reg_val,
                                          input logic [31:0] mem_val, input logic [31:0] wb_val);
    case (sel)
      FWD_MEM: return mem_val;
      FWD_WB:  return wb_val;
      default: return reg_val;
    endcase
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/execute_stage_div_unit.sv
// Iterative radix-2 restoring divider with IDLE/BUSY/DONE sequencing and
// RISC-V divide-by-zero / overflow results.
module div_unit
  import execute_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        signed_op,
  input  logic        want_rem,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        idle,
  output logic [31:0] result
);

  div_state_e  state, state_next;
  logic [4:0]  cnt;
  logic [31:0] quo, rem, dvsr, dividend;
  logic        neg_q, neg_r, div_zero, rem_sel;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift, diff;
  logic [31:0] q_fix, r_fix;

  assign a_neg     = signed_op & a[31];
  assign b_neg     = signed_op & b[31];
  assign a_mag     = a_neg ? (32'd0 - a) : a;
  assign b_mag     = b_neg ? (32'd0 - b) : b;
  assign rem_shift = {rem, quo[31]};
  assign diff      = rem_shift - {1'b0, dvsr};

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      DIV_IDLE: begin
        busy = start;
        if (start) state_next = DIV_BUSY;
      end
      DIV_BUSY: begin
        busy = 1'b1;
        if (abort) state_next = DIV_IDLE;
        else if (cnt == 5'(DIV_CYCLES - 1)) state_next = DIV_DONE;
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  assign done = (state == DIV_DONE);
  assign idle = (state == DIV_IDLE);

  // The quotient register doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      dividend <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      rem_sel  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DIV_IDLE && start) begin
        quo      <= a_mag;
        rem      <= '0;
        dvsr     <= b_mag;
        dividend <= a;
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        div_zero <= (b == 32'd0);
        rem_sel  <= want_rem;
        cnt      <= '0;
      end else if (state == DIV_BUSY && !abort) begin
        rem <= diff[32] ? rem_shift[31:0] : diff[31:0];
        quo <= {quo[30:0], ~diff[32]};
        cnt <= cnt + 5'd1;
      end
    end
  end

  assign q_fix = neg_q ? (32'd0 - quo) : quo;
  assign r_fix = neg_r ? (32'd0 - rem) : rem;

  always_comb begin
    result = rem_sel ? r_fix : q_fix;
    if (div_zero) result = rem_sel ? dividend : 32'hFFFF_FFFF;
  end

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: forwarding, ALU, branch resolution and the
// iterative divider, feeding the EX/MEM pipeline register.
module execute_stage
  import execute_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  id_ex_t      id_ex,
  input  logic [1:0]  fwd_a_sel,
  input  logic [1:0]  fwd_b_sel,
  input  logic [31:0] fwd_mem_data,
  input  logic [31:0] fwd_wb_data,
  input  logic        flush,
  output ex_mem_t     ex_mem,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        ex_busy
);

  logic [31:0] op_a, fwd_b, op_b, alu_out, div_result;
  logic        is_div, div_start, div_busy, div_done, div_idle;
  logic        br_cond, jalr;
  ex_mem_t     ex_mem_next;

  assign op_a  = fwd_mux(fwd_a_sel, id_ex.rs1_data, fwd_mem_data, fwd_wb_data);
  assign fwd_b = fwd_mux(fwd_b_sel, id_ex.rs2_data, fwd_mem_data, fwd_wb_data);
  assign op_b  = id_ex.alu_src ? id_ex.imm : fwd_b;

  always_comb begin
    alu_out = '0;
    case (id_ex.alu_op)
      ALU_ADD:   alu_out = op_a + op_b;
      ALU_SUB:   alu_out = op_a - op_b;
      ALU_AND:   alu_out = op_a & op_b;
      ALU_OR:    alu_out = op_a | op_b;
      ALU_XOR:   alu_out = op_a ^ op_b;
      ALU_SLL:   alu_out = op_a << op_b[4:0];
      ALU_SRL:   alu_out = op_a >> op_b[4:0];
      ALU_SRA:   alu_out = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:   alu_out = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:  alu_out = {31'b0, op_a < op_b};
      ALU_PASSB: alu_out = op_b;
      ALU_AUIPC: alu_out = id_ex.pc + id_ex.imm;
      default:   alu_out = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (id_ex.br_op)
      BR_BEQ:  br_cond = (op_a == fwd_b);
      BR_BNE:  br_cond = (op_a != fwd_b);
      BR_BLT:  br_cond = ($signed(op_a) < $signed(fwd_b));
      BR_BGE:  br_cond = ($signed(op_a) >= $signed(fwd_b));
      BR_BLTU: br_cond = (op_a < fwd_b);
      BR_BGEU: br_cond = (op_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr          = id_ex.Jump & id_ex.alu_src;
  assign branch_target = jalr ? ((op_a + id_ex.imm) & ~32'h1) : (id_ex.pc + id_ex.imm);
  assign branch_taken  = id_ex.valid & ~flush & div_idle &
                         (id_ex.Jump | (id_ex.Branch & br_cond));

  assign is_div    = is_div_op(id_ex.alu_op);
  assign div_start = id_ex.valid & is_div & ~flush;

  div_unit #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (div_start),
    .abort    (flush),
    .signed_op((id_ex.alu_op == ALU_DIV) || (id_ex.alu_op == ALU_REM)),
    .want_rem ((id_ex.alu_op == ALU_REM) || (id_ex.alu_op == ALU_REMU)),
    .a        (op_a),
    .b        (fwd_b),
    .busy     (div_busy),
    .done     (div_done),
    .idle     (div_idle),
    .result   (div_result)
  );

  assign ex_busy = reset_n & div_busy;

  // DONE is checked before busy so the held divide is not mistaken for a new start.
  always_comb begin
    ex_mem_next = '0;
    if (flush) begin
      ex_mem_next = '0;
    end else if (div_done) begin
      ex_mem_next.alu_result = div_result;
      ex_mem_next.rs2_data   = fwd_b;
      ex_mem_next.rd         = id_ex.rd;
      ex_mem_next.RegWrite   = id_ex.RegWrite;
      ex_mem_next.valid      = id_ex.valid;
    end else if (div_busy || !id_ex.valid) begin
      ex_mem_next = '0;
    end else begin
      ex_mem_next.alu_result = id_ex.Jump ? (id_ex.pc + 32'd4) : alu_out;
      ex_mem_next.rs2_data   = fwd_b;
      ex_mem_next.rd         = id_ex.rd;
      ex_mem_next.RegWrite   = id_ex.RegWrite;
      ex_mem_next.MemWrite   = id_ex.MemWrite;
      ex_mem_next.MemToReg   = id_ex.MemToReg;
      ex_mem_next.valid      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ex_mem <= '0;
    else          ex_mem <= ex_mem_next;
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases with literal results
// plus randomized instructions checked against a cycle-level behavioural model.
module tb_execute_stage;
  import execute_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  id_ex_t      id_ex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        flush;
  ex_mem_t     ex_mem;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ex_busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  execute_stage #(.DIV_CYCLES(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_ex        (id_ex),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .fwd_mem_data (fwd_mem_data),
    .fwd_wb_data  (fwd_wb_data),
    .flush        (flush),
    .ex_mem       (ex_mem),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ex_busy      (ex_busy)
  );

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input id_ex_t ins, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [31:0] mem, input logic [31:0] wb, input logic fl);
    id_ex        = ins;
    fwd_a_sel    = fa;
    fwd_b_sel    = fb;
    fwd_mem_data = mem;
    fwd_wb_data  = wb;
    flush        = fl;
  endtask

  function automatic id_ex_t mkInstr(input alu_op_e op, input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    id_ex_t ins;
    ins          = '0;
    ins.alu_op   = op;
    ins.rs1_data = rs1;
    ins.rs2_data = rs2;
    ins.imm      = imm;
    ins.pc       = pc;
    ins.rd       = rd;
    ins.valid    = 1'b1;
    return ins;
  endfunction

  // ---------------- behavioural reference ----------------
  function automatic logic [31:0] fwdVal(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'b01) return fwd_mem_data;
    if (sel == 2'b10) return fwd_wb_data;
    return r;
  endfunction

  function automatic logic [31:0] aluModel(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] pc, input logic [31:0] imm);
    int sh;
    sh = int'(b % 32);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << sh;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return 32'($signed(a) >>> sh);
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASSB: return b;
      ALU_AUIPC: return pc + imm;
      default:   return 32'd0;
    endcase
  endfunction

  function automatic logic branchModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] divModel(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      ALU_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM:  return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  // phase: 0 = no divide pending, 1..32 = divider iterating, 33 = result cycle
  int          phase    = 0;
  int          exp_kind = 0;
  ex_mem_t     exp_em;
  logic [31:0] div_a, div_b;
  alu_op_e     div_op;

  always @(negedge clk) begin
    logic [31:0] a_v, fb_v, b_v, exp_target;
    logic        is_div, exp_busy, exp_taken;
    case (exp_kind)
      1: checkOutput("ex_mem_reset", 96'(ex_mem), '0);
      2: checkOutput("bubble_flags", 96'({ex_mem.valid, ex_mem.RegWrite, ex_mem.MemWrite}), '0);
      3: begin
        checkOutput("alu_result", 96'(ex_mem.alu_result), 96'(exp_em.alu_result));
        checkOutput("rs2_data", 96'(ex_mem.rs2_data), 96'(exp_em.rs2_data));
        checkOutput("ctrl", 96'({ex_mem.rd, ex_mem.RegWrite, ex_mem.MemWrite, ex_mem.MemToReg, ex_mem.valid}),
                    96'({exp_em.rd, exp_em.RegWrite, exp_em.MemWrite, exp_em.MemToReg, exp_em.valid}));
      end
      4: begin
        checkOutput("div_result", 96'(ex_mem.alu_result), 96'(exp_em.alu_result));
        checkOutput("div_rs2_data", 96'(ex_mem.rs2_data), 96'(exp_em.rs2_data));
        checkOutput("div_ctrl", 96'({ex_mem.rd, ex_mem.RegWrite, ex_mem.MemWrite, ex_mem.valid}),
                    96'({exp_em.rd, exp_em.RegWrite, exp_em.MemWrite, exp_em.valid}));
      end
      default: ;
    endcase

    if (!reset_n) begin
      checkOutput("busy_in_reset", 96'(ex_busy), '0);
      exp_kind = 1;
      phase    = 0;
    end else begin
      a_v    = fwdVal(fwd_a_sel, id_ex.rs1_data);
      fb_v   = fwdVal(fwd_b_sel, id_ex.rs2_data);
      b_v    = id_ex.alu_src ? id_ex.imm : fb_v;
      is_div = id_ex.alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      exp_busy  = (phase >= 1 && phase <= 32) || (phase == 0 && id_ex.valid && is_div && !flush);
      exp_taken = (phase == 0) && id_ex.valid && !flush &&
                  (id_ex.Jump || (id_ex.Branch && branchModel(id_ex.br_op, a_v, fb_v)));
      exp_target = (id_ex.Jump && id_ex.alu_src) ? ((a_v + id_ex.imm) & ~32'h1) : (id_ex.pc + id_ex.imm);
      checkOutput("ex_busy", 96'(ex_busy), 96'(exp_busy));
      checkOutput("branch_taken", 96'(branch_taken), 96'(exp_taken));
      checkOutput("branch_target", 96'(branch_target), 96'(exp_target));

      exp_em = '0;
      if (flush) begin
        exp_kind = 2;
        phase    = 0;
      end else if (phase == 0) begin
        if (!id_ex.valid) begin
          exp_kind = 2;
        end else if (is_div) begin
          div_a    = a_v;
          div_b    = fb_v;
          div_op   = id_ex.alu_op;
          exp_kind = 2;
          phase    = 1;
        end else begin
          exp_em.alu_result = id_ex.Jump ? id_ex.pc + 32'd4
                                         : aluModel(id_ex.alu_op, a_v, b_v, id_ex.pc, id_ex.imm);
          exp_em.rs2_data = fb_v;
          exp_em.rd       = id_ex.rd;
          exp_em.RegWrite = id_ex.RegWrite;
          exp_em.MemWrite = id_ex.MemWrite;
          exp_em.MemToReg = id_ex.MemToReg;
          exp_em.valid    = 1'b1;
          exp_kind        = 3;
        end
      end else if (phase <= 32) begin
        exp_kind = 2;
        phase++;
      end else begin
        exp_em.alu_result = divModel(div_op, div_a, div_b);
        exp_em.rs2_data   = fb_v;
        exp_em.rd         = id_ex.rd;
        exp_em.RegWrite   = id_ex.RegWrite;
        exp_em.valid      = id_ex.valid;
        exp_kind          = 4;
        phase             = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] randData();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom % 16;
      4:       return 32'd0 - ($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  function automatic id_ex_t randInstr();
    id_ex_t ins;
    ins          = '0;
    ins.pc       = $urandom & ~32'h3;
    ins.rs1_data = randData();
    ins.rs2_data = randData();
    ins.imm      = randData();
    ins.rd       = 5'($urandom);
    ins.valid    = ($urandom % 10) != 0;
    case ($urandom_range(0, 5))
      0: begin ins.alu_op = alu_op_e'(4'($urandom_range(0, 11))); ins.RegWrite = 1'b1; end
      1: begin ins.alu_op = alu_op_e'(4'($urandom_range(0, 11))); ins.alu_src = 1'b1; ins.RegWrite = 1'b1; end
      2: begin
        ins.alu_op  = ALU_ADD;
        ins.alu_src = 1'b1;
        if ($urandom % 2) ins.MemWrite = 1'b1;
        else begin ins.MemToReg = 1'b1; ins.RegWrite = 1'b1; end
      end
      3: begin ins.alu_op = ALU_SUB; ins.Branch = 1'b1; ins.br_op = 3'($urandom); end
      4: begin ins.alu_op = ALU_ADD; ins.Jump = 1'b1; ins.alu_src = 1'($urandom); ins.RegWrite = 1'b1; end
      default: begin ins.alu_op = alu_op_e'(4'($urandom_range(12, 15))); ins.RegWrite = 1'b1; end
    endcase
    return ins;
  endfunction

  task automatic runDivide(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] expected, input string name);
    id_ex_t ins;
    int busy_cycles = 0;
    int early_valid = 0;
    ins = mkInstr(op, a, b, 32'd0, 32'h80, 5'd9);
    ins.RegWrite = 1'b1;
    applyStimulus(ins, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 34; i++) begin
      #1;
      if (ex_busy === 1'b1) busy_cycles++;
      step();
      if (i < 33 && ex_mem.valid !== 1'b0) early_valid++;
    end
    checkOutput({name, "_busy_cycles"}, 96'(busy_cycles), 96'(33));
    checkOutput({name, "_early_valid"}, 96'(early_valid), '0);
    checkOutput(name, 96'(ex_mem.alu_result), 96'(expected));
    checkOutput({name, "_ctrl"}, 96'({ex_mem.valid, ex_mem.RegWrite, ex_mem.rd}), 96'({2'b11, 5'd9}));
  endtask

  initial begin
    id_ex_t ins;
    logic   saw_valid;
    reset_n = 1'b0;
    applyStimulus('0, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    repeat (3) step();
    checkOutput("reset_ex_mem", 96'(ex_mem), '0);
    checkOutput("reset_busy", 96'(ex_busy), '0);
    reset_n = 1'b1;

    ins = mkInstr(ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
    ins.RegWrite = 1'b1;
    applyStimulus(ins, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    step();
    checkOutput("add_5_7", 96'(ex_mem.alu_result), 96'(12));
    checkOutput("add_flags", 96'({ex_mem.valid, ex_mem.RegWrite}), 96'(2'b11));

    ins = mkInstr(ALU_ADD, 32'h55, 32'd0, 32'd4, 32'd0, 5'd4);
    ins.alu_src = 1'b1; ins.RegWrite = 1'b1;
    applyStimulus(ins, 2'b01, 2'b00, 32'h100, 32'd0, 1'b0);
    step();
    checkOutput("fwd_mem_add", 96'(ex_mem.alu_result), 96'(32'h104));

    ins = mkInstr(ALU_ADD, 32'h200, 32'h11, 32'd8, 32'd0, 5'd0);
    ins.alu_src = 1'b1; ins.MemWrite = 1'b1;
    applyStimulus(ins, 2'b00, 2'b10, 32'd0, 32'hAB, 1'b0);
    step();
    checkOutput("store_data", 96'(ex_mem.rs2_data), 96'(32'hAB));
    checkOutput("store_memwrite", 96'(ex_mem.MemWrite), 96'(1));

    ins = mkInstr(ALU_SUB, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h40, 5'd0);
    ins.Branch = 1'b1; ins.br_op = BR_BLT;
    applyStimulus(ins, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("blt_taken", 96'(branch_taken), 96'(1));
    checkOutput("blt_target", 96'(branch_target), 96'(32'h50));
    step();
    ins.br_op = BR_BLTU;
    applyStimulus(ins, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("bltu_taken", 96'(branch_taken), 96'(0));
    step();

    runDivide(ALU_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div_m7_2");
    runDivide(ALU_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem_m7_2");
    runDivide(ALU_DIVU, 32'd9,         32'd0,        32'hFFFF_FFFF, "divu_9_0");
    runDivide(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        "rem_ovf");
    runDivide(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");

    ins = mkInstr(ALU_DIV, 32'd100, 32'd3, 32'd0, 32'd0, 5'd7);
    ins.RegWrite = 1'b1;
    applyStimulus(ins, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    step();
    repeat (9) step();
    flush = 1'b1;
    step();
    applyStimulus('0, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("flush_busy_drop", 96'(ex_busy), '0);
    saw_valid = 1'b0;
    repeat (40) begin
      step();
      if (ex_mem.valid !== 1'b0) saw_valid = 1'b1;
    end
    checkOutput("flush_no_result", 96'(saw_valid), '0);

    applyStimulus(ins, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    repeat (6) step();
    reset_n = 1'b0;
    step();
    checkOutput("reset_mid_div_ex_mem", 96'(ex_mem), '0);
    reset_n = 1'b1;
    applyStimulus('0, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    #1;
    checkOutput("reset_mid_div_idle", 96'(ex_busy), '0);
    step();

    for (int n = 0; n < 200; n++) begin
      logic [1:0] fa, fb;
      ins = randInstr();
      fa  = 2'($urandom);
      fb  = 2'($urandom);
      if (ins.alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) begin
        int flush_at;
        flush_at = (($urandom % 4) == 0) ? int'($urandom_range(1, 33)) : 0;
        applyStimulus(ins, fa, fb, randData(), randData(), 1'b0);
        step();
        for (int k = 1; k <= 33; k++) begin
          if (k == flush_at) begin
            flush = 1'b1;
            step();
            break;
          end
          fwd_mem_data = randData();
          fwd_wb_data  = randData();
          step();
        end
      end else begin
        applyStimulus(ins, fa, fb, randData(), randData(), ($urandom % 8) == 0);
        step();
      end
    end

    applyStimulus('0, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0);
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
